// File: rtl/ft232h_tx_arbiter.sv
// FT232H synchronous-FIFO transmit arbiter.
// Round-robins whole packets from two show-ahead source FIFOs. Each packet is a
// three-byte header (sync, channel/sequence id, length) followed by PKT_LEN
// payload bytes. The FT232H byte/strobe pair is a one-deep output register that
// holds its byte until the device accepts it.
module ft232h_tx_arbiter #(
    parameter int           PKT_LEN   = 64,
    parameter logic [7:0]   SYNC_BYTE = 8'hA5
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        en_i,
    input  logic [7:0]  src0_data_i,
    input  logic [7:0]  src1_data_i,
    input  logic        src0_empty_i,
    input  logic        src1_empty_i,
    input  logic [8:0]  src0_level_i,
    input  logic [8:0]  src1_level_i,
    output logic        src0_rd_o,
    output logic        src1_rd_o,
    input  logic        ft_txe_i,
    output logic [7:0]  ft_adbus_o,
    output logic        ft_wr_o,
    output logic        ft_rd_o,
    output logic        ft_oe_o,
    output logic        busy_o,
    output logic [6:0]  seq_o
);

    localparam logic [8:0] LEN9 = 9'(PKT_LEN);
    localparam logic [7:0] LEN8 = 8'(PKT_LEN);

    typedef enum logic [2:0] {
        IDLE,
        HDR_SYNC,
        HDR_ID,
        HDR_LEN,
        PAYLOAD
    } state_t;

    state_t      state_q;
    logic        ch_q;       // source granted to the current packet
    logic        rr_q;       // source preferred on the next tie
    logic [6:0]  seq_q;
    logic [7:0]  cnt_q;      // payload bytes loaded so far
    logic [7:0]  adbus_q;
    logic        wr_n_q;

    logic        xfer;
    logic        out_free;
    logic        elig0;
    logic        elig1;
    logic        grant_ch;
    logic        head_empty;
    logic [7:0]  head_data;
    logic        pay_load;

    // Output-register handshake, eligibility and granted-source head selection.
    always_comb begin
        xfer       = !wr_n_q && !ft_txe_i;
        out_free   = wr_n_q || xfer;
        elig0      = src0_level_i >= LEN9;
        elig1      = src1_level_i >= LEN9;
        grant_ch   = (elig0 && elig1) ? rr_q : elig1;
        head_empty = ch_q ? src1_empty_i : src0_empty_i;
        head_data  = ch_q ? src1_data_i : src0_data_i;
        // A pop happens exactly when the head byte is captured by the output register.
        pay_load   = (state_q == PAYLOAD) && out_free && !head_empty && !rst_i;
        src0_rd_o  = pay_load && !ch_q;
        src1_rd_o  = pay_load && ch_q;
    end

    // Packet sequencer together with the FT232H output register.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            ch_q    <= 1'b0;
            rr_q    <= 1'b0;
            seq_q   <= '0;
            cnt_q   <= '0;
            adbus_q <= '0;
            wr_n_q  <= 1'b1;
        end else begin
            // Accepted byte frees the register; a load below re-arms the strobe.
            if (xfer) begin
                wr_n_q <= 1'b1;
            end
            unique case (state_q)
                IDLE: begin
                    if (en_i && (elig0 || elig1)) begin
                        ch_q    <= grant_ch;
                        rr_q    <= ~grant_ch;
                        cnt_q   <= '0;
                        state_q <= HDR_SYNC;
                    end
                end
                HDR_SYNC: begin
                    if (out_free) begin
                        adbus_q <= SYNC_BYTE;
                        wr_n_q  <= 1'b0;
                        state_q <= HDR_ID;
                    end
                end
                HDR_ID: begin
                    if (out_free) begin
                        adbus_q <= {ch_q, seq_q};
                        wr_n_q  <= 1'b0;
                        state_q <= HDR_LEN;
                    end
                end
                HDR_LEN: begin
                    if (out_free) begin
                        adbus_q <= LEN8;
                        wr_n_q  <= 1'b0;
                        state_q <= PAYLOAD;
                    end
                end
                PAYLOAD: begin
                    if (pay_load) begin
                        adbus_q <= head_data;
                        wr_n_q  <= 1'b0;
                        cnt_q   <= cnt_q + 8'd1;
                        if (cnt_q == LEN8 - 8'd1) begin
                            seq_q   <= seq_q + 7'd1;
                            state_q <= IDLE;
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign ft_adbus_o = adbus_q;
    assign ft_wr_o    = wr_n_q;
    assign ft_rd_o    = 1'b1;
    assign ft_oe_o    = 1'b1;
    assign seq_o      = seq_q;
    // The last payload byte may still sit in the output register after IDLE is reached.
    assign busy_o     = (state_q != IDLE) || !wr_n_q;

endmodule

// File: doc/ft232h_tx_arbiter.md
FT232H_TX_ARBITER -- requirements
Module: ft232h_tx_arbiter

Interface
REQ-001 SHALL expose parameter PKT_LEN, default 64, payload bytes per packet (legal 1..255).
REQ-002 SHALL expose parameter SYNC_BYTE, default 8'hA5, first header byte of every packet.
REQ-003 SHALL have port clk_i  in  1  60 MHz FT232H clock; all logic on its rising edge.
REQ-004 SHALL have port rst_i  in  1  reset, synchronous and active-high.
REQ-005 SHALL have port en_i  in  1  start-of-packet permission.
REQ-006 SHALL have ports src0_data_i / src1_data_i  in  8  show-ahead FIFO head byte (0 = ADC samples, 1 = status).
REQ-007 SHALL have ports src0_empty_i / src1_empty_i  in  1  source FIFO empty.
REQ-008 SHALL have ports src0_level_i / src1_level_i  in  9  source FIFO fill count.
REQ-009 SHALL have ports src0_rd_o / src1_rd_o  out  1  pop strobe, one byte per cycle.
REQ-010 SHALL have port ft_txe_i  in  1  high = FT232H TX FIFO full, do not write.
REQ-011 SHALL have port ft_adbus_o  out  8  byte to FT232H.
REQ-012 SHALL have port ft_wr_o  out  1  active-low write strobe.
REQ-013 SHALL have ports ft_rd_o, ft_oe_o  out  1  tied high (no reads).
REQ-014 SHALL have port busy_o  out  1  high while a packet is in progress.
REQ-015 SHALL have port seq_o  out  7  sequence number of the next packet.

Function
REQ-016 SHALL transmit packets: SYNC_BYTE, {ch[0], seq[6:0]}, PKT_LEN[7:0], then PKT_LEN payload bytes from source ch.
REQ-017 SHALL define transfer xfer = (ft_wr_o==0) && (ft_txe_i==0) at a rising edge; exactly one byte is consumed per xfer.
REQ-018 SHALL register ft_adbus_o and ft_wr_o; a presented byte with ft_wr_o low SHALL be held unchanged until xfer.
REQ-019 SHALL load the next byte into the output register in any cycle where (ft_wr_o==1 || xfer) and that byte is available; otherwise drive ft_wr_o high after xfer.
REQ-020 SHALL use states IDLE, HDR_SYNC, HDR_ID, HDR_LEN, PAYLOAD.
REQ-021 IDLE: when en_i=1 and a source has level >= PKT_LEN, SHALL grant one source, latch ch, go to HDR_SYNC next cycle.
REQ-022 Arbitration SHALL be round-robin per packet: if both eligible, grant the source not served by the previous packet; after reset, source 0 wins the first tie.
REQ-023 HDR_SYNC, HDR_ID, HDR_LEN SHALL each load their byte when the output register is free and advance on that load.
REQ-024 PAYLOAD: SHALL assert srcN_rd_o for exactly the cycle its head byte is loaded into ft_adbus_o; never pop when srcN_empty_i=1.
REQ-025 PAYLOAD: if granted source empties mid-packet, SHALL stall (no pop, ft_wr_o high after pending xfer) until non-empty; packet is never truncated.
REQ-026 SHALL count payload loads with an 8-bit counter; after the PKT_LEN-th load, SHALL return to IDLE and increment seq (mod 128).
REQ-027 ft_txe_i high SHALL stall the sequence at any byte without loss or duplication; no popping while the output register is occupied and not transferring.
REQ-028 en_i deasserted mid-packet SHALL NOT abort; the packet completes, then IDLE holds.
REQ-029 Non-granted source SHALL never see its rd_o asserted.
REQ-030 busy_o SHALL be high in every state except IDLE and while the final payload byte remains untransferred.
REQ-031 Back-to-back packets SHALL be separated by at least one IDLE cycle.

Reset
REQ-032 On rst_i=1 at a clock edge: state IDLE, ft_wr_o=1, ft_adbus_o=0, src*_rd_o=0, busy_o=0, seq_o=0, RR pointer to source 0, ft_rd_o=ft_oe_o=1.
REQ-033 Reset mid-packet SHALL discard the pending byte and partial packet; no pop in the reset cycle.

Verification
REQ-034 PKT_LEN=4, src0 level 4 bytes 01..04, txe low -> ft bytes A5,00,04,01,02,03,04 on consecutive cycles, 4 pops, seq_o=1.
REQ-035 Both sources level>=PKT_LEN continuously -> packet IDs alternate 0x00,0x81,0x02,0x83.
REQ-036 txe pulsed high 3 cycles during payload byte 2 -> byte held stable, each byte appears exactly once in FT stream.
REQ-037 src0 empties after 2 payload bytes for 5 cycles -> ft_wr_o high during gap, no pops, packet resumes, total payload = PKT_LEN.
REQ-038 en_i dropped during HDR_LEN -> packet completes; no new packet while en_i=0.
REQ-039 rst_i during PAYLOAD -> next cycle ft_wr_o=1, busy_o=0, seq_o=0; next packet restarts at SYNC_BYTE.
